// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle RV32I datapath; sequences fetch/decode/execute/mem/writeback.
// Latency: outputs are combinational from the registered state; 2..5 cycles per instruction, FETCH included.
// Backpressure: none; one state step per clock, and reset overrides all strobes in the cycle it is seen.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   op, func3       opcode and funct3 fields from the instruction register
//   zero, lt        ALU flags, used only for the branch decision
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUOp, ImmSrc, RegWrite   datapath enables/selects and ALU controller op
//   illegal         one-cycle pulse in DECODE on an unsupported opcode
module multicycle_main_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRPC   = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    state_t state;
    logic   op_legal;
    logic   br_taken;

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Unlisted funct3 encodings simply fall through as not-taken.
    always_comb begin
        br_taken = 1'b0;
        case (func3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = ~lt;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECUTER;
                        OP_I:         state <= S_EXECUTEI;
                        OP_BR:        state <= S_BRANCH;
                        OP_JAL:       state <= S_JAL;
                        OP_JALR:      state <= S_JALR;
                        OP_LUI:       state <= S_LUI;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (op == OP_LW)      state <= S_MEMREAD;
                    else if (op == OP_SW) state <= S_MEMWRITE;
                    else                  state <= S_FETCH;
                end
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_JALR:     state <= S_JALRPC;
                S_JALRPC:   state <= S_ALUWB;
                S_LUI:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;

        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase

        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                // Precompute OldPC + imm into ALUOut for branch/jal targets.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = ~op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                // PC loads the target already sitting in ALUOut when taken.
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = br_taken;
            end
            S_JAL: begin
                // PC <- OldPC+imm from ALUOut while the ALU forms OldPC+4 for the link.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JALRPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_LUI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            default: begin
            end
        endcase

        // Reset cycle: no writes of any kind, selects parked at FETCH values.
        if (rst) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            illegal   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b00;
            ResultSrc = 2'b10;
        end
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Scoreboard bench: each issued instruction pushes its expected per-cycle control words;
// a negedge monitor pops one word per cycle and compares against the DUT outputs.
// Expected words come from an instruction-level reference model of the control sequence.
module tb_multicycle_main_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic       zero;
    logic       lt;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q[$];
    string       tag_q[$];
    logic [16:0] got;

    multicycle_main_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .zero(zero), .lt(lt),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUOp, ImmSrc, RegWrite, illegal};

    // Control word layout: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc RegWrite illegal
    function automatic logic [16:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic [2:0] imm,
                                       input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, aop, imm, rw, ill};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        if (o == 7'b0110111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic l);
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        if (f3 == 3'b100) return l;
        if (f3 == 3'b101) return !l;
        return 1'b0;
    endfunction

    // Monitor: one comparison per cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s t=%0t: got %b required %b (op=%b f3=%b)", t, $time, got, e, op, func3);
            end
        end
    end

    task automatic expect_word(input logic [16:0] w, input string t);
        exp_q.push_back(w);
        tag_q.push_back(t);
    endtask

    // Issue one instruction starting in FETCH; rst_at >= 0 asserts reset in that cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input logic l, input int rst_at, input string t);
        logic [16:0] seq[$];
        logic [2:0]  im;
        logic [16:0] aluwb;
        int          n;
        op = o; func3 = f3; zero = z; lt = l;
        im    = imm_of(o);
        aluwb = cw(0,0,0,0,2'b00,2'b00,2'b00,2'b00,im,1,0);
        seq.push_back(cw(1,0,0,1,2'b10,2'b00,2'b10,2'b00,im,0,0));
        case (o)
            7'b0110011: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b00,2'b10,2'b00,2'b10,im,0,0));
                seq.push_back(aluwb);
            end
            7'b0010011: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b00,2'b10,2'b01,2'b11,im,0,0));
                seq.push_back(aluwb);
            end
            7'b0000011: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,1,0,0,2'b00,2'b00,2'b00,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b01,2'b00,2'b00,2'b00,im,1,0));
            end
            7'b0100011: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,1,1,0,2'b00,2'b00,2'b00,2'b00,im,0,0));
            end
            7'b1100011: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(taken_of(f3,z,l),0,0,0,2'b00,2'b10,2'b00,2'b01,im,0,0));
            end
            7'b1101111: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(1,0,0,0,2'b00,2'b01,2'b10,2'b00,im,0,0));
                seq.push_back(aluwb);
            end
            7'b1100111: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b00,2'b10,2'b01,2'b00,im,0,0));
                seq.push_back(cw(1,0,0,0,2'b00,2'b01,2'b10,2'b00,im,0,0));
                seq.push_back(aluwb);
            end
            7'b0110111: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,0));
                seq.push_back(cw(0,0,0,0,2'b11,2'b00,2'b00,2'b00,im,1,0));
            end
            default: begin
                seq.push_back(cw(0,0,0,0,2'b00,2'b01,2'b01,2'b00,im,0,1));
            end
        endcase
        n = seq.size();
        if (rst_at >= 0 && rst_at < n) begin
            while (seq.size() > rst_at) void'(seq.pop_back());
            seq.push_back(cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,im,0,0));
            n = rst_at + 1;
        end
        foreach (seq[k]) expect_word(seq[k], t);
        for (int i = 0; i < n; i++) begin
            rst = (i == rst_at);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    logic [6:0] legal_ops[8];

    initial begin
        rst = 1'b1; op = 7'b0110011; func3 = 3'b000; zero = 1'b0; lt = 1'b0;
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        @(posedge clk); #1;
        // Two reset cycles: strobes off, FETCH selects.
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1;
            expect_word(cw(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0), "reset");
            @(posedge clk); #1;
        end
        rst = 1'b0;

        run_instr(7'b0110011, 3'b000, 0, 0, -1, "rtype");
        run_instr(7'b0000011, 3'b010, 0, 0, -1, "lw");
        run_instr(7'b0100011, 3'b010, 0, 0, -1, "sw");
        run_instr(7'b1100011, 3'b000, 1, 0, -1, "beq_taken");
        run_instr(7'b1100011, 3'b000, 0, 0, -1, "beq_not");
        run_instr(7'b1100011, 3'b101, 0, 1, -1, "bge_lt");
        run_instr(7'b1100011, 3'b110, 1, 1, -1, "br_f3_110");
        run_instr(7'b1101111, 3'b000, 0, 0, -1, "jal");
        run_instr(7'b1100111, 3'b000, 0, 0, -1, "jalr");
        run_instr(7'b0110111, 3'b000, 0, 0, -1, "lui");
        run_instr(7'b1111111, 3'b000, 0, 0, -1, "illegal");
        run_instr(7'b0100011, 3'b010, 0, 0, 2, "sw_midreset");
        run_instr(7'b0010011, 3'b000, 0, 0, -1, "after_reset");

        for (int i = 0; i < 400; i++) begin
            logic [6:0] o;
            int         r;
            if ($urandom_range(0, 7) == 0) o = 7'($urandom);
            else                           o = legal_ops[$urandom_range(0, 7)];
            r = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), r, "random");
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
